// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencer: write-enable/bubble/flush controls from memory wait, multiply, load-use and branch.
// Decisions are combinational (0-cycle); only FSM state, multiply countdown and stall counter are registered.
module pipe_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        IDEX_MemRead_i,
    input  logic        IDEX_Mul_i,
    input  logic [4:0]  IDEX_RTaddr_i,
    input  logic [4:0]  IFID_RSaddr_i,
    input  logic [4:0]  IFID_RTaddr_i,
    input  logic        Branch_i,
    input  logic        MemReady_i,
    output logic        PCWrite_o,
    output logic        IFIDWrite_o,
    output logic        IFIDFlush_o,
    output logic        IDEXWrite_o,
    output logic        IDEXBubble_o,
    output logic        EXMEMWrite_o,
    output logic        EXMEMBubble_o,
    output logic        MEMWBBubble_o,
    output logic        Busy_o,
    output logic [15:0] StallCnt_o
);

    typedef enum logic [0:0] {RUN, MUL_BUSY} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        stall_q, stall_d;
    logic               load_use;

    assign load_use = IDEX_MemRead_i && (IDEX_RTaddr_i != 5'd0) &&
                      ((IDEX_RTaddr_i == IFID_RSaddr_i) || (IDEX_RTaddr_i == IFID_RTaddr_i));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        PCWrite_o     = 1'b1;
        IFIDWrite_o   = 1'b1;
        IFIDFlush_o   = 1'b0;
        IDEXWrite_o   = 1'b1;
        IDEXBubble_o  = 1'b0;
        EXMEMWrite_o  = 1'b1;
        EXMEMBubble_o = 1'b0;
        MEMWBBubble_o = 1'b0;
        Busy_o        = (state_q == MUL_BUSY) || !MemReady_i;

        if (!rst_i) begin
            // Keep clocking the pipeline with NOPs so it drains cleanly during reset.
            IFIDFlush_o   = 1'b1;
            IDEXBubble_o  = 1'b1;
            EXMEMBubble_o = 1'b1;
            MEMWBBubble_o = 1'b1;
            Busy_o        = 1'b0;
        end else if (!MemReady_i) begin
            PCWrite_o     = 1'b0;
            IFIDWrite_o   = 1'b0;
            IDEXWrite_o   = 1'b0;
            EXMEMWrite_o  = 1'b0;
            MEMWBBubble_o = 1'b1;
        end else if (state_q == MUL_BUSY) begin
            if (cnt_q != '0) begin
                PCWrite_o     = 1'b0;
                IFIDWrite_o   = 1'b0;
                IDEXWrite_o   = 1'b0;
                EXMEMBubble_o = 1'b1;
                cnt_d         = cnt_q - CNT_W'(1);
            end else begin
                state_d     = RUN;
                IFIDFlush_o = Branch_i;
            end
        end else if (IDEX_Mul_i) begin
            // First EX cycle of the multiply counts toward MUL_LAT; release cycle is the last.
            PCWrite_o     = 1'b0;
            IFIDWrite_o   = 1'b0;
            IDEXWrite_o   = 1'b0;
            EXMEMBubble_o = 1'b1;
            cnt_d         = CNT_W'(MUL_LAT - 2);
            state_d       = MUL_BUSY;
        end else if (load_use) begin
            // Branch in ID is dropped here; it resolves again once the load data is forwardable.
            PCWrite_o    = 1'b0;
            IFIDWrite_o  = 1'b0;
            IDEXBubble_o = 1'b1;
        end else if (Branch_i) begin
            IFIDFlush_o = 1'b1;
        end
    end

    assign stall_d    = (!PCWrite_o && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;
    assign StallCnt_o = stall_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

endmodule
